// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pkg
// Brief   : Shared encodings for the TinyCPU MEM stage: mem2wb bus layout,
//           memory-op and access-size codes, MEM FSM state codes.
// Revision: 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // Default datapath geometry; the bus layout below assumes these values.
  localparam int unsigned c_XLEN   = 32;
  localparam int unsigned c_REG_AW = 5;

  // mem2wb bus: {pc[XLEN], rf_we, rd[REG_AW], wdata[XLEN]}, MSB first.
  localparam int unsigned MEM2WB_BUS_SIZE = 2 * c_XLEN + c_REG_AW + 1;
  localparam int unsigned c_BUS_WDATA_LSB = 0;
  localparam int unsigned c_BUS_RD_LSB    = c_XLEN;
  localparam int unsigned c_BUS_WE_BIT    = c_XLEN + c_REG_AW;
  localparam int unsigned c_BUS_PC_LSB    = c_XLEN + c_REG_AW + 1;

  // Memory operation codes; code 3 is reserved and behaves as no-op.
  localparam logic [1:0] c_MEM_NONE  = 2'd0;
  localparam logic [1:0] c_MEM_LOAD  = 2'd1;
  localparam logic [1:0] c_MEM_STORE = 2'd2;

  // Access sizes; code 3 is handled as a word access.
  localparam logic [1:0] c_SZ_B = 2'd0;
  localparam logic [1:0] c_SZ_H = 2'd1;
  localparam logic [1:0] c_SZ_W = 2'd2;

  // MEM FSM states.
  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_REQ  = 2'd1;
  localparam logic [1:0] c_S_WAIT = 2'd2;
  localparam logic [1:0] c_S_DONE = 2'd3;

  // True for the two op codes that touch the data port.
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == c_MEM_LOAD) || (op == c_MEM_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu_align
// Brief   : Combinational lane logic for the data port: byte strobes, store
//           data replication, load byte/half extraction and extension.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lsu_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      i_mem_op,
  input  logic [1:0]      i_mem_size,
  input  logic            i_mem_signed,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_st_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_wstrb,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_fill;
  logic        w_half_fill;

  // Byte strobes: only stores enable lanes; accesses are naturally aligned.
  always_comb begin
    o_wstrb = 4'b0000;
    if (i_mem_op == c_MEM_STORE) begin
      case (i_mem_size)
        c_SZ_B:  o_wstrb = 4'b0001 << i_off;
        c_SZ_H:  o_wstrb = 4'b0011 << i_off;
        default: o_wstrb = 4'b1111;
      endcase
    end
  end

  // Replicate the LSB-aligned store data across every lane it could target.
  always_comb begin
    case (i_mem_size)
      c_SZ_B:  o_wdata = {(XLEN/8){i_st_data[7:0]}};
      c_SZ_H:  o_wdata = {(XLEN/16){i_st_data[15:0]}};
      default: o_wdata = i_st_data;
    endcase
  end

  // Pick the addressed lane out of the read word and sign/zero-extend it.
  always_comb begin
    w_byte      = i_rdata[{i_off, 3'b000} +: 8];
    w_half      = i_rdata[{i_off[1], 4'b0000} +: 16];
    w_byte_fill = i_mem_signed & w_byte[7];
    w_half_fill = i_mem_signed & w_half[15];
    case (i_mem_size)
      c_SZ_B:  o_ldata = {{(XLEN-8){w_byte_fill}}, w_byte};
      c_SZ_H:  o_ldata = {{(XLEN-16){w_half_fill}}, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage
// Brief   : TinyCPU MEM pipeline stage. Issues loads/stores on an SRAM-like
//           req/addr_ok/data_ok port, extends load data and holds the result
//           on the mem2wb bus until WB accepts it.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ctl_mem_valid_i,
  output logic                   ctl_mem_allow_in_o,
  output logic                   ctl_mem_over_o,
  input  logic                   ctl_wb_allow_in_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [1:0]             mem_op_i,
  input  logic [1:0]             mem_size_i,
  input  logic                   mem_signed_i,
  input  logic [XLEN-1:0]        alu_res_i,
  input  logic [XLEN-1:0]        st_data_i,
  input  logic [REG_AW-1:0]      rd_i,
  input  logic                   rf_we_i,
  output logic                   data_req_o,
  output logic                   data_wr_o,
  output logic [3:0]             data_wstrb_o,
  output logic [XLEN-1:0]        data_addr_o,
  output logic [XLEN-1:0]        data_wdata_o,
  input  logic                   data_addr_ok_i,
  input  logic [XLEN-1:0]        data_rdata_i,
  input  logic                   data_data_ok_i,
  output logic [2*XLEN+REG_AW:0] mem2wb_bus_o
);

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [XLEN-1:0] r_result;

  logic            w_mem;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_req;
  logic            w_over;
  logic            w_rf_we;
  logic [XLEN-1:0] w_wb_data;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata_rep;
  logic [XLEN-1:0] w_ldata;

  assign w_mem      = ctl_mem_valid_i && is_mem_op(mem_op_i);
  assign w_is_load  = (mem_op_i == c_MEM_LOAD);
  assign w_is_store = (mem_op_i == c_MEM_STORE);

  mem_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .i_mem_op     (mem_op_i),
    .i_mem_size   (mem_size_i),
    .i_mem_signed (mem_signed_i),
    .i_off        (alu_res_i[1:0]),
    .i_st_data    (st_data_i),
    .i_rdata      (data_rdata_i),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata_rep),
    .o_ldata      (w_ldata)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Result register: captures the writeback value when the response lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= '0;
    end else if ((r_state == c_S_WAIT) && data_data_ok_i) begin
      r_result <= w_is_load ? w_ldata : alu_res_i;
    end
  end

  // Next-state logic; responses outside WAIT are stale and ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_mem && data_addr_ok_i) begin
          w_next = c_S_WAIT;
        end else if (w_mem) begin
          w_next = c_S_REQ;
        end
      end
      c_S_REQ: begin
        if (data_addr_ok_i) begin
          w_next = c_S_WAIT;
        end
      end
      c_S_WAIT: begin
        if (data_data_ok_i) begin
          w_next = c_S_DONE;
        end
      end
      default: begin
        if (ctl_wb_allow_in_i) begin
          w_next = c_S_IDLE;
        end
      end
    endcase
  end

  // Output decode; reset forces request/over low without waiting for a clock.
  always_comb begin
    w_req     = 1'b0;
    w_over    = 1'b0;
    w_wb_data = alu_res_i;
    case (r_state)
      c_S_IDLE: begin
        w_req  = w_mem;
        w_over = ctl_mem_valid_i && !w_mem;
      end
      c_S_REQ: begin
        w_req = 1'b1;
      end
      c_S_WAIT: begin
        w_req = 1'b0;
      end
      default: begin
        w_over    = 1'b1;
        w_wb_data = r_result;
      end
    endcase
    if (!rst_ni) begin
      w_req  = 1'b0;
      w_over = 1'b0;
    end
  end

  // Stores never write the register file.
  assign w_rf_we = rf_we_i && !w_is_store;

  assign data_req_o         = w_req;
  assign data_wr_o          = w_req && w_is_store;
  assign data_wstrb_o       = w_req ? w_wstrb : 4'b0000;
  assign data_addr_o        = w_req ? alu_res_i : '0;
  assign data_wdata_o       = w_req ? w_wdata_rep : '0;
  assign ctl_mem_over_o     = w_over;
  assign ctl_mem_allow_in_o = !rst_ni || !ctl_mem_valid_i || (w_over && ctl_wb_allow_in_i);
  assign mem2wb_bus_o       = w_over ? {pc_i, w_rf_we, rd_i, w_wb_data} : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage
// Brief   : Self-checking bench for mem_stage: vector table for single-cycle
//           behaviour, scripted load/store transactions with a scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int BW     = 2 * XLEN + REG_AW + 1;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic              allow_in;
  logic              over;
  logic              wb_allow;
  logic [XLEN-1:0]   pc;
  logic [1:0]        mem_op;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   st_data;
  logic [REG_AW-1:0] rd;
  logic              rf_we;
  logic              req;
  logic              wr;
  logic [3:0]        wstrb;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              addr_ok;
  logic [XLEN-1:0]   rdata;
  logic              data_ok;
  logic [BW-1:0]     bus;

  mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .ctl_mem_valid_i    (valid),
    .ctl_mem_allow_in_o (allow_in),
    .ctl_mem_over_o     (over),
    .ctl_wb_allow_in_i  (wb_allow),
    .pc_i               (pc),
    .mem_op_i           (mem_op),
    .mem_size_i         (mem_size),
    .mem_signed_i       (mem_signed),
    .alu_res_i          (alu_res),
    .st_data_i          (st_data),
    .rd_i               (rd),
    .rf_we_i            (rf_we),
    .data_req_o         (req),
    .data_wr_o          (wr),
    .data_wstrb_o       (wstrb),
    .data_addr_o        (addr),
    .data_wdata_o       (wdata),
    .data_addr_ok_i     (addr_ok),
    .data_rdata_i       (rdata),
    .data_data_ok_i     (data_ok),
    .mem2wb_bus_o       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] sb_q[$];

  typedef struct {
    logic              valid;
    logic [1:0]        op;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              wb;
    logic              aok;
    logic              exp_over;
    logic              exp_allow;
    logic [BW-1:0]     exp_bus;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic v, input logic [1:0] op, input logic [31:0] p,
                               input logic [31:0] a, input logic [4:0] r, input logic we,
                               input logic wb, input logic aok);
    vec_t t;
    t.valid     = v;
    t.op        = op;
    t.pc        = p;
    t.alu       = a;
    t.rd        = r;
    t.we        = we;
    t.wb        = wb;
    t.aok       = aok;
    // Only valid non-memory ops complete in the same cycle.
    t.exp_over  = v && (op == 2'd0 || op == 2'd3);
    t.exp_allow = !v || (t.exp_over && wb);
    t.exp_bus   = t.exp_over ? {p, we, r, a} : '0;
    return t;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a);
    if (op != 2'd2) return 4'h0;
    case (sz)
      2'd0:    return 4'b0001 << a[1:0];
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_rep(input logic [1:0] sz, input logic [31:0] s);
    logic [31:0] r;
    int w;
    w = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[8*(i % w) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * a[1:0]);
    case (sz)
      2'd0:    return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      2'd1:    return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: return d;
    endcase
  endfunction

  // One load/store from a drive point to the next; expected bus goes to sb_q.
  task automatic mem_txn(input string tag, input logic [1:0] op, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] a, input logic [31:0] st,
                         input logic [31:0] rdv, input logic [31:0] p, input logic [4:0] r,
                         input logic we, input int a_dly, input int d_dly, input int hold);
    logic [31:0]   res;
    logic [BW-1:0] expb;
    bit            seen;
    res  = (op == 2'd1) ? m_load(sz, sgn, a, rdv) : a;
    expb = {p, (op == 2'd2) ? 1'b0 : we, r, res};
    sb_q.push_back(expb);
    valid = 1'b1; mem_op = op; mem_size = sz; mem_signed = sgn;
    alu_res = a; st_data = st; pc = p; rd = r; rf_we = we;
    data_ok = 1'b0; wb_allow = 1'b1;
    for (int k = 0; k <= a_dly; k++) begin
      addr_ok = (k == a_dly);
      @(negedge clk);
      chk({tag, " req"}, BW'(req), BW'(1'b1));
      chk({tag, " addr"}, BW'(addr), BW'(a));
      chk({tag, " wr"}, BW'(wr), BW'(op == 2'd2));
      chk({tag, " wstrb"}, BW'(wstrb), BW'(m_strb(op, sz, a)));
      if (op == 2'd2) chk({tag, " wdata"}, BW'(wdata), BW'(m_rep(sz, st)));
      chk({tag, " over in req"}, BW'(over), '0);
      chk({tag, " allow in req"}, BW'(allow_in), '0);
      cyc();
    end
    addr_ok = 1'b0;
    for (int k = 1; k <= d_dly; k++) begin
      data_ok = (k == d_dly);
      rdata   = (k == d_dly) ? rdv : 32'hDEAD_BEEF;
      @(negedge clk);
      chk({tag, " req in wait"}, BW'(req), '0);
      chk({tag, " over in wait"}, BW'(over), '0);
      cyc();
    end
    data_ok  = 1'b0;
    rdata    = 32'h5A5A_A5A5;
    wb_allow = (hold == 0);
    seen     = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (over) seen = 1'b1;
      else cyc();
    end
    chk({tag, " over seen"}, BW'(seen), BW'(1'b1));
    if (!seen) begin
      void'(sb_q.pop_front());
      valid = 1'b0;
      cyc();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk({tag, " hold over"}, BW'(over), BW'(1'b1));
      chk({tag, " hold allow"}, BW'(allow_in), '0);
      chk({tag, " hold req"}, BW'(req), '0);
      chk({tag, " hold bus"}, bus, sb_q[0]);
      cyc();
      wb_allow = (h + 1 >= hold);
      @(negedge clk);
    end
    chk({tag, " done over"}, BW'(over), BW'(1'b1));
    chk({tag, " done allow"}, BW'(allow_in), BW'(1'b1));
    chk({tag, " bus"}, bus, sb_q.pop_front());
    cyc();
    valid = 1'b0; mem_op = 2'd0;
    @(negedge clk);
    chk({tag, " idle over"}, BW'(over), '0);
    chk({tag, " idle allow"}, BW'(allow_in), BW'(1'b1));
    chk({tag, " idle req"}, BW'(req), '0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b1; mem_op = 2'd0; mem_size = 2'd0; mem_signed = 1'b0;
    alu_res = 32'h77; st_data = '0; pc = '0; rd = '0; rf_we = 1'b1; wb_allow = 1'b1;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    #2;
    chk("reset over", BW'(over), '0);
    chk("reset allow", BW'(allow_in), BW'(1'b1));
    chk("reset req", BW'(req), '0);
    chk("reset bus", bus, '0);
    cyc();
    rst_n = 1'b1;
    valid = 1'b0;

    vt[0] = mkv(1'b0, 2'd0, 32'h0,         32'h0,         5'd0,  1'b0, 1'b1, 1'b0);
    vt[1] = mkv(1'b1, 2'd0, 32'h100,       32'h1234,      5'd3,  1'b1, 1'b1, 1'b0);
    vt[2] = mkv(1'b1, 2'd3, 32'h200,       32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b1);
    vt[3] = mkv(1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0,         5'd0,  1'b1, 1'b1, 1'b1);
    vt[4] = mkv(1'b0, 2'd1, 32'h300,       32'h44,        5'd9,  1'b1, 1'b1, 1'b0);
    vt[5] = mkv(1'b1, 2'd0, 32'h400,       32'hCAFE_F00D, 5'd17, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      valid = vt[i].valid; mem_op = vt[i].op; pc = vt[i].pc; alu_res = vt[i].alu;
      rd = vt[i].rd; rf_we = vt[i].we; wb_allow = vt[i].wb; addr_ok = vt[i].aok;
      @(negedge clk);
      chk($sformatf("vec%0d over", i), BW'(over), BW'(vt[i].exp_over));
      chk($sformatf("vec%0d allow", i), BW'(allow_in), BW'(vt[i].exp_allow));
      chk($sformatf("vec%0d req", i), BW'(req), '0);
      chk($sformatf("vec%0d wstrb", i), BW'(wstrb), '0);
      chk($sformatf("vec%0d bus", i), bus, vt[i].exp_bus);
      cyc();
    end
    valid = 1'b0; addr_ok = 1'b0; wb_allow = 1'b1;

    mem_txn("lb_s",   2'd1, 2'd0, 1'b1, 32'h1003, 32'h0,         32'h80FF_0000, 32'h500, 5'd4,  1'b1, 0, 2, 0);
    mem_txn("sh",     2'd2, 2'd1, 1'b0, 32'h2002, 32'hABCD,      32'h0,         32'h504, 5'd5,  1'b1, 3, 1, 0);
    mem_txn("lw_hold",2'd1, 2'd2, 1'b0, 32'h3000, 32'h0,         32'h1234_5678, 32'h508, 5'd6,  1'b1, 0, 1, 5);

    // Reset while waiting for data, then a stale response after release.
    valid = 1'b1; mem_op = 2'd1; mem_size = 2'd2; alu_res = 32'h40; addr_ok = 1'b1;
    @(negedge clk);
    chk("rst pre req", BW'(req), BW'(1'b1));
    cyc();
    addr_ok = 1'b0;
    @(negedge clk);
    chk("rst wait req", BW'(req), '0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst async req", BW'(req), '0);
    chk("rst async over", BW'(over), '0);
    chk("rst async allow", BW'(allow_in), BW'(1'b1));
    chk("rst async bus", bus, '0);
    cyc();
    rst_n = 1'b1; valid = 1'b0; mem_op = 2'd0; data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stale over", BW'(over), '0);
    chk("stale req", BW'(req), '0);
    cyc();
    data_ok = 1'b0;
    @(negedge clk);
    chk("stale after over", BW'(over), '0);
    chk("stale after allow", BW'(allow_in), BW'(1'b1));
    cyc();

    mem_txn("lhu",    2'd1, 2'd1, 1'b0, 32'h0002, 32'h0,         32'h8001_0000, 32'h600, 5'd7,  1'b1, 1, 1, 0);
    mem_txn("sb",     2'd2, 2'd0, 1'b0, 32'h4001, 32'h1122_335A, 32'h0,         32'h604, 5'd8,  1'b1, 0, 3, 0);
    mem_txn("sw",     2'd2, 2'd2, 1'b0, 32'h5000, 32'hA5A5_0F0F, 32'h0,         32'h608, 5'd9,  1'b0, 2, 1, 2);
    mem_txn("lbu",    2'd1, 2'd0, 1'b0, 32'h6002, 32'h0,         32'h00C3_0000, 32'h60C, 5'd10, 1'b1, 0, 1, 0);
    mem_txn("lh_s",   2'd1, 2'd1, 1'b1, 32'h7000, 32'h0,         32'h0000_9ABC, 32'h610, 5'd11, 1'b1, 0, 1, 0);
    mem_txn("l_sz3",  2'd1, 2'd3, 1'b1, 32'h8000, 32'h0,         32'h8765_4321, 32'h614, 5'd12, 1'b1, 1, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
